// File: rtl/addsub_serial_ctrl.sv
// Bit-serial WIDTH-bit unsigned add/subtract: one bit per cycle, LSB first,
// with operand latching and a start/busy/done handshake.
module addsub_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SumDiff,
    output logic             CarryBorrow
);
    localparam int             IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_work;
    logic             r_mode, r_c;
    logic [IW-1:0]    r_idx;

    logic             w_a, w_b, w_bit, w_c_nxt;
    logic [WIDTH-1:0] w_work_nxt;

    // One-bit add/subtract cell; c is carry for add, borrow for subtract.
    always_comb begin
        w_a   = r_a[r_idx];
        w_b   = r_b[r_idx];
        w_bit = w_a ^ w_b ^ r_c;
        if (r_mode) w_c_nxt = (~w_a & w_b) | (r_c & ~(w_a ^ w_b));
        else        w_c_nxt = (w_a & w_b) | (r_c & (w_a ^ w_b));
        w_work_nxt        = r_work;
        w_work_nxt[r_idx] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_work      <= '0;
            r_mode      <= 1'b0;
            r_c         <= 1'b0;
            r_idx       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            SumDiff     <= '0;
            CarryBorrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_mode  <= mode;
                        r_c     <= 1'b0;
                        r_idx   <= '0;
                        r_work  <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_work <= w_work_nxt;
                    r_c    <= w_c_nxt;
                    r_idx  <= r_idx + 1'b1;
                    // Final bit: publish straight from the cell so the result
                    // lands on the same edge the last bit is computed.
                    if (r_idx == LAST) begin
                        SumDiff     <= w_work_nxt;
                        CarryBorrow <= w_c_nxt;
                        r_idx       <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl: WIDTH=8 and WIDTH=1 instances, vector table,
// hand-written corner sequences and randomized ops against an arithmetic model.
module tb_addsub_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, mode = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       busy, done, cb;
    logic [7:0] sd;
    logic       start1 = 1'b0, mode1 = 1'b0;
    logic [0:0] A1 = '0, B1 = '0;
    logic       busy1, done1, cb1;
    logic [0:0] sd1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] prev_sd = '0;
    logic       prev_cb = 1'b0;

    always #5 clk = ~clk;

    addsub_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
        .busy(busy), .done(done), .SumDiff(sd), .CarryBorrow(cb));
    addsub_serial_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .A(A1), .B(B1),
        .busy(busy1), .done(done1), .SumDiff(sd1), .CarryBorrow(cb1));

    typedef struct {
        logic       m;
        logic [7:0] a, b, esd;
        logic       ecb;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Invariant: busy and done are never high together.
    always @(negedge clk) begin
        if (!rst && ((busy && done) || (busy1 && done1))) begin
            n_err++;
            $display("FAIL busy_done_overlap: got busy=%0b/%0b done=%0b/%0b expected no overlap",
                     busy, busy1, done, done1);
        end
    end

    task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] esd, input logic esb, input string tag);
        int lat, nb, holdbad;
        start = 1'b1; mode = m; A = a; B = b;
        tick;
        start = 1'b0; A = 8'($urandom); B = 8'($urandom); mode = 1'($urandom);
        lat = 1; nb = 0; holdbad = 0;
        while (!done && lat < 30) begin
            if (busy) nb++;
            if (sd !== prev_sd || cb !== prev_cb) holdbad++;
            tick;
            lat++;
        end
        chk({tag, " latency"}, lat, 9);
        chk({tag, " busy_cycles"}, nb, 8);
        chk({tag, " hold"}, holdbad, 0);
        chk({tag, " SumDiff"}, sd, esd);
        chk({tag, " CarryBorrow"}, cb, esb);
        prev_sd = sd; prev_cb = cb;
        tick;
    endtask

    task automatic run1(input logic m, input logic a, input logic b);
        int lat, nb;
        logic [1:0] s;
        logic       esd, ecb;
        s   = m ? 2'({1'b0, a}) - 2'({1'b0, b}) : 2'({1'b0, a}) + 2'({1'b0, b});
        esd = s[0];
        ecb = m ? (a < b) : s[1];
        start1 = 1'b1; mode1 = m; A1 = a; B1 = b;
        tick;
        start1 = 1'b0; A1 = ~a; B1 = ~b; mode1 = ~m;
        lat = 1; nb = 0;
        while (!done1 && lat < 10) begin
            if (busy1) nb++;
            tick;
            lat++;
        end
        chk($sformatf("w1 m%0b %0b,%0b latency", m, a, b), lat, 2);
        chk($sformatf("w1 m%0b %0b,%0b busy", m, a, b), nb, 1);
        chk($sformatf("w1 m%0b %0b,%0b SumDiff", m, a, b), sd1, esd);
        chk($sformatf("w1 m%0b %0b,%0b CarryBorrow", m, a, b), cb1, ecb);
        tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int   pulses, busy_after, bad, last_done, nbad_int;
        logic [7:0] ra, rb, esd;
        logic [8:0] s9;
        logic       rm, ecb;

        vt[0] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vt[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1};
        vt[2] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b0};
        vt[3] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
        vt[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[5] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};
        vt[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vt[7] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0};

        // Reset state
        tick; tick;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst SumDiff", sd, 0);
        chk("rst CarryBorrow", cb, 0);
        rst = 1'b0;
        tick;
        chk("idle busy", busy, 0);
        chk("idle w1 busy", busy1, 0);

        for (int i = 0; i < 8; i++)
            run8(vt[i].m, vt[i].a, vt[i].b, vt[i].esd, vt[i].ecb, $sformatf("vec%0d", i));

        // start during RUN is dropped
        start = 1'b1; mode = 1'b0; A = 8'h12; B = 8'h34;
        tick;
        start = 1'b0; tick; tick;
        start = 1'b1; mode = 1'b1; A = 8'hFF; B = 8'h01;
        tick;
        start = 1'b0;
        pulses = 0; busy_after = 0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                pulses++;
                chk("drop SumDiff", sd, 8'h46);
                chk("drop CarryBorrow", cb, 0);
            end else if (pulses > 0 && busy) busy_after++;
            tick;
        end
        chk("drop pulses", pulses, 1);
        chk("drop no_second_op", busy_after, 0);
        prev_sd = sd; prev_cb = cb;

        // reset mid-RUN
        start = 1'b1; mode = 1'b0; A = 8'h3C; B = 8'h0F;
        tick;
        start = 1'b0; tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst SumDiff", sd, 0);
        chk("midrst CarryBorrow", cb, 0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (done || busy) pulses++;
            tick;
        end
        chk("midrst abandoned", pulses, 0);
        prev_sd = 8'h00; prev_cb = 1'b0;
        run8(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, "after_rst");

        // start held high: one op per 10 cycles
        start = 1'b1; mode = 1'b0; A = 8'h01; B = 8'h02;
        pulses = 0; bad = 0; last_done = -1; nbad_int = 0;
        for (int c = 0; c < 45; c++) begin
            tick;
            if (done) begin
                if (last_done >= 0 && c - last_done != 10) nbad_int++;
                last_done = c;
                pulses++;
            end
            if (pulses > 0 && sd !== 8'h03) bad++;
        end
        start = 1'b0;
        chk("held pulses", pulses, 4);
        chk("held interval", nbad_int, 0);
        chk("held stable", bad, 0);
        for (int c = 0; c < 12; c++) tick;
        prev_sd = 8'h03; prev_cb = 1'b0;

        // randomized ops against arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
            if (rm) begin
                esd = ra - rb;
                ecb = (ra < rb);
            end else begin
                s9  = {1'b0, ra} + {1'b0, rb};
                esd = s9[7:0];
                ecb = s9[8];
            end
            run8(rm, ra, rb, esd, ecb, $sformatf("rnd%0d m%0b %02h,%02h", i, rm, ra, rb));
        end

        // WIDTH=1 exhaustive
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    run1(1'(m), 1'(a), 1'(b));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_serial_ctrl.md
# addsub_serial_ctrl

Bit-serial sequencer that performs WIDTH-bit unsigned addition or subtraction using one 1-bit add/subtract cell per cycle, LSB first. It wraps the half-adder/half-subtractor datapath with carry/borrow chaining, operand latching and a start/busy/done handshake. Upstream control logic uses it to get multi-bit results without instantiating a full-width adder.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when the block is idle
- mode  input  1  0 = add, 1 = subtract; sampled with start
- A  input  WIDTH  first operand; sampled with start
- B  input  WIDTH  second operand; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result and CarryBorrow are valid
- SumDiff  output  WIDTH  (A+B) mod 2^WIDTH, or (A−B) mod 2^WIDTH
- CarryBorrow  output  1  add: carry out of the MSB; subtract: 1 iff A < B (unsigned)

## Operation
- One clock, clk. Reset is synchronous, active-high on rst.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: publishes the result for one cycle.
- IDLE → RUN: when start=1. In that cycle A, B and mode go into internal registers. The bit index and the chain bit c are cleared to 0. The working shift register is cleared.
- RUN, bit i per cycle (a=A[i], b=B[i]):
  - The bit result is a^b^c.
  - Add: next c = (a&b) | (c&(a^b)).
  - Subtract: next c = (~a&b) | (c&~(a^b)).
  - The bit result is written to bit i of the working register.
- RUN → DONE: after bit WIDTH−1 is processed. At that edge SumDiff is loaded from the working register and CarryBorrow from the final c.
- DONE → IDLE: unconditionally after one cycle.
- start is ignored in RUN and DONE. No queuing; the request is dropped.
- Changes to A, B or mode after acceptance have no effect on the operation in progress.
- SumDiff and CarryBorrow change only on the RUN→DONE edge or on reset. They hold their values through the following IDLE and the whole next RUN.
- Reset at any time, including mid-RUN:
  - State goes to IDLE and the operation is abandoned.
  - busy=0, done=0.
  - SumDiff=0, CarryBorrow=0.
  - Internal registers and the index are cleared.
  - No done pulse is produced for the abandoned operation.
- rst has priority over start in the same cycle.

## Timing
- Reset values:
  - state IDLE
  - busy 0
  - done 0
  - SumDiff 0
  - CarryBorrow 0
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Cycle schedule, with start sampled high in IDLE at edge t:
  - busy=1 in cycles t+1 through t+WIDTH, processing bits 0..WIDTH−1.
  - done=1 and busy=0 in cycle t+WIDTH+1. SumDiff and CarryBorrow are valid from this cycle.
  - Cycle t+WIDTH+2 is IDLE. The earliest next acceptance is at edge t+WIDTH+2.
- Latency from start to done is WIDTH+1 cycles. Back-to-back throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together.
- WIDTH=1: one RUN cycle, then DONE.

## Test plan
1. WIDTH=8, add, A=0xFF, B=0x01, start for 1 cycle.
   - busy high for exactly 8 cycles.
   - done at start+9, with SumDiff=0x00 and CarryBorrow=1.
2. WIDTH=8, subtract, A=0x05, B=0x07 → SumDiff=0xFE, CarryBorrow=1. Then subtract A=0x80, B=0x80 → SumDiff=0x00, CarryBorrow=0.
3. Start add A=0x12, B=0x34. At start+3, assert start with subtract A=0xFF, B=0x01 and change A/B/mode.
   - Only one done pulse, with SumDiff=0x46 and CarryBorrow=0.
   - No second operation follows.
4. Start add A=0x3C, B=0x0F. Assert rst for one cycle at start+4.
   - Next cycle: busy=0, done=0, SumDiff=0, CarryBorrow=0.
   - No done pulse for the abandoned operation.
   - A new add A=0x01, B=0x01 then yields 0x02.
5. start held high continuously with add A=0x01, B=0x02.
   - done pulses every 10 cycles.
   - SumDiff=0x03 stays stable between pulses.
6. WIDTH=1:
   - add 1+1 → SumDiff=0, CarryBorrow=1, done at start+2.
   - subtract 0−1 → SumDiff=1, CarryBorrow=1.
